// File: rtl/s2_lane_feeder_if.sv
// Bundle between the lane producers / s2 consumer side and s2_lane_feeder.
// master drives the input lanes and observes s2 inputs; slave is the feeder itself.
interface s2_lane_feeder_if #(
    parameter int unsigned N = 1
);
    logic [N-1:0] in_data0;
    logic [N-1:0] in_data1;
    logic [N-1:0] in_data2;
    logic [N-1:0] in_data3;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;

    logic [N-1:0] D0;
    logic [N-1:0] D1;
    logic [N-1:0] D2;
    logic [N-1:0] D3;
    logic         A1;
    logic         B1;
    logic         A0;
    logic         B0;
    logic         s2_clr;
    logic         out_valid;
    logic [1:0]   out_lane;

    modport master (
        output in_data0, in_data1, in_data2, in_data3, in_valid,
        input  in_ready,
        input  D0, D1, D2, D3, A1, B1, A0, B0, s2_clr, out_valid, out_lane
    );

    modport slave (
        input  in_data0, in_data1, in_data2, in_data3, in_valid,
        output in_ready,
        output D0, D1, D2, D3, A1, B1, A0, B0, s2_clr, out_valid, out_lane
    );
endinterface

// File: rtl/s2_lane_feeder.sv
// Four-lane one-deep buffer with round-robin pick, driving the select/clr pins of
// the registered 4:1 cell s2 and tagging which lane s2 will present next cycle.
module s2_lane_feeder #(
    parameter int unsigned N = 1
) (
    input logic              clk,
    input logic              clr_n,
    s2_lane_feeder_if.slave  bus
);

    logic [N-1:0] buf_q [4];
    logic [N-1:0] in_data [4];
    logic [3:0]   full_q;
    logic [3:0]   full_d;
    logic [1:0]   ptr_q;
    logic         out_valid_q;
    logic [1:0]   out_lane_q;

    logic         gv;
    logic [1:0]   g;
    logic [3:0]   grant_oh;
    logic [3:0]   ready;
    logic [3:0]   xfer;

    assign in_data[0] = bus.in_data0;
    assign in_data[1] = bus.in_data1;
    assign in_data[2] = bus.in_data2;
    assign in_data[3] = bus.in_data3;

    // Walk from the farthest offset down so the lane nearest ptr wins.
    always_comb begin
        gv = 1'b0;
        g  = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (full_q[ptr_q + 2'(i)]) begin
                gv = 1'b1;
                g  = ptr_q + 2'(i);
            end
        end
    end

    always_comb begin
        grant_oh = 4'b0000;
        if (gv) begin
            grant_oh = 4'b0001 << g;
        end
    end

    // A granted lane drains this edge, so it may refill in the same cycle.
    assign ready  = clr_n ? (~full_q | grant_oh) : 4'b0000;
    assign xfer   = bus.in_valid & ready;
    assign full_d = (full_q & ~grant_oh) | xfer;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int k = 0; k < 4; k++) begin
                buf_q[k] <= '0;
            end
            full_q      <= 4'b0000;
            ptr_q       <= 2'd0;
            out_valid_q <= 1'b0;
            out_lane_q  <= 2'd0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (xfer[k]) begin
                    buf_q[k] <= in_data[k];
                end
            end
            full_q <= full_d;
            if (gv) begin
                ptr_q <= g + 2'd1;
            end
            out_valid_q <= gv;
            out_lane_q  <= gv ? g : 2'd0;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.D0        = buf_q[0];
    assign bus.D1        = buf_q[1];
    assign bus.D2        = buf_q[2];
    assign bus.D3        = buf_q[3];

    // s2 decodes S1 = A1|B1 and S0 = A0&B0, so B1 is parked low and A0/B0 move together.
    assign bus.A1        = gv & g[1];
    assign bus.B1        = 1'b0;
    assign bus.A0        = gv & g[0];
    assign bus.B0        = gv & g[0];
    assign bus.s2_clr    = ~gv;
    assign bus.out_valid = out_valid_q;
    assign bus.out_lane  = out_lane_q;

endmodule

// File: tb/tb_s2_lane_feeder.sv
// Directed bench for s2_lane_feeder with a behavioural s2 cell and per-lane scoreboard.
module tb_s2_lane_feeder;
    localparam int unsigned N = 4;

    logic clk;
    logic clr_n;
    int   checks;
    int   errors;

    s2_lane_feeder_if #(.N(N)) bus ();

    s2_lane_feeder #(.N(N)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural s2: registered 4:1 select with synchronous clear.
    logic [N-1:0] s2_out;
    logic [N-1:0] s2_mux;
    logic [1:0]   s2_sel;
    assign s2_sel = {bus.A1 | bus.B1, bus.A0 & bus.B0};
    always_comb begin
        case (s2_sel)
            2'd0:    s2_mux = bus.D0;
            2'd1:    s2_mux = bus.D1;
            2'd2:    s2_mux = bus.D2;
            default: s2_mux = bus.D3;
        endcase
    end
    initial s2_out = '0;
    always @(posedge clk) s2_out <= bus.s2_clr ? '0 : s2_mux;

    logic [N-1:0] q0[$];
    logic [N-1:0] q1[$];
    logic [N-1:0] q2[$];
    logic [N-1:0] q3[$];
    logic [3:0]   last_acc;
    logic [3:0]   last_rdy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: log handshakes before the edge, score s2 output after it.
    task automatic tick();
        logic [N-1:0] exp;
        int           depth;
        @(negedge clk);
        last_rdy = bus.in_ready;
        last_acc = bus.in_valid & bus.in_ready;
        if (last_acc[0]) q0.push_back(bus.in_data0);
        if (last_acc[1]) q1.push_back(bus.in_data1);
        if (last_acc[2]) q2.push_back(bus.in_data2);
        if (last_acc[3]) q3.push_back(bus.in_data3);
        @(posedge clk);
        #1;
        if (bus.out_valid) begin
            exp = '0;
            case (bus.out_lane)
                2'd0:    begin depth = q0.size(); if (depth != 0) exp = q0.pop_front(); end
                2'd1:    begin depth = q1.size(); if (depth != 0) exp = q1.pop_front(); end
                2'd2:    begin depth = q2.size(); if (depth != 0) exp = q2.pop_front(); end
                default: begin depth = q3.size(); if (depth != 0) exp = q3.pop_front(); end
            endcase
            check("sb_nonempty", 32'(depth != 0), 32'd1);
            check("sb_data", 32'(s2_out), 32'(exp));
        end else begin
            check("idle_out", 32'(s2_out), 32'd0);
        end
    endtask

    task automatic all_lanes();
        bus.in_data0 = 4'h1;
        bus.in_data1 = 4'h2;
        bus.in_data2 = 4'h3;
        bus.in_data3 = 4'h4;
        bus.in_valid = 4'b1111;
        tick();
        check("all_accept", 32'(last_acc), 32'hF);
        bus.in_valid = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("all_valid", 32'(bus.out_valid), 32'd1);
            check("all_lane", 32'(bus.out_lane), 32'(i));
            check("all_data", 32'(s2_out), 32'(i + 1));
        end
        tick();
        check("all_done", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        clr_n = 1'b0;
        bus.in_valid = 4'b0000;
        bus.in_data0 = '0;
        bus.in_data1 = '0;
        bus.in_data2 = '0;
        bus.in_data3 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check("rst_clr", 32'(bus.s2_clr), 32'd1);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_lane", 32'(bus.out_lane), 32'd0);
        check("rst_sel", 32'({bus.A1, bus.B1, bus.A0, bus.B0}), 32'd0);
        check("rst_d", 32'({bus.D3, bus.D2, bus.D1, bus.D0}), 32'd0);
        clr_n = 1'b1;

        // Idle
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_clr", 32'(bus.s2_clr), 32'd1);
            check("idle_sel", 32'({bus.A1, bus.B1, bus.A0, bus.B0}), 32'd0);
            check("idle_valid", 32'(bus.out_valid), 32'd0);
        end

        all_lanes();

        // Fairness: lanes 0 and 3 held valid
        bus.in_data0 = 4'h1;
        bus.in_data3 = 4'h8;
        bus.in_valid = 4'b1001;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (last_acc[0]) bus.in_data0 = bus.in_data0 + 4'h1;
            if (last_acc[3]) bus.in_data3 = bus.in_data3 + 4'h1;
            if (k >= 2) begin
                check("fair_valid", 32'(bus.out_valid), 32'd1);
                check("fair_lane", 32'(bus.out_lane), (k % 2 == 0) ? 32'd0 : 32'd3);
            end
        end
        bus.in_valid = 4'b0000;
        repeat (4) tick();

        // Single word on lane 2
        bus.in_data2 = 4'hA;
        bus.in_valid = 4'b0100;
        tick();
        bus.in_valid = 4'b0000;
        check("sw_sel", 32'({bus.A1, bus.B1, bus.A0, bus.B0}), 32'b1000);
        check("sw_clr", 32'(bus.s2_clr), 32'd0);
        tick();
        check("sw_valid", 32'(bus.out_valid), 32'd1);
        check("sw_lane", 32'(bus.out_lane), 32'd2);
        check("sw_data", 32'(s2_out), 32'hA);
        check("sw_clr_after", 32'(bus.s2_clr), 32'd1);

        // Streaming on lane 1
        bus.in_data1 = 4'h1;
        bus.in_valid = 4'b0010;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("st_ready", 32'(last_rdy[1]), 32'd1);
            if (last_acc[1]) bus.in_data1 = bus.in_data1 + 4'h1;
            if (k >= 2) begin
                check("st_valid", 32'(bus.out_valid), 32'd1);
                check("st_lane", 32'(bus.out_lane), 32'd1);
                check("st_data", 32'(s2_out), 32'(k - 1));
            end
        end
        bus.in_valid = 4'b0000;
        repeat (3) tick();

        // Reset mid-traffic
        bus.in_data0 = 4'h5;
        bus.in_data1 = 4'h6;
        bus.in_data2 = 4'h7;
        bus.in_data3 = 4'h8;
        bus.in_valid = 4'b1111;
        repeat (2) tick();
        #2;
        clr_n = 1'b0;
        #1;
        check("mid_ready", 32'(bus.in_ready), 32'd0);
        check("mid_clr", 32'(bus.s2_clr), 32'd1);
        check("mid_valid", 32'(bus.out_valid), 32'd0);
        check("mid_sel", 32'({bus.A1, bus.B1, bus.A0, bus.B0}), 32'd0);
        q0.delete();
        q1.delete();
        q2.delete();
        q3.delete();
        @(posedge clk);
        #1;
        check("mid_hold_ready", 32'(bus.in_ready), 32'd0);
        check("mid_s2_out", 32'(s2_out), 32'd0);
        clr_n = 1'b1;
        all_lanes();

        check("sb_drained", 32'(q0.size() + q1.size() + q2.size() + q3.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/s2_lane_feeder.md
Name: s2_lane_feeder

Overview:
- Upstream feeder for the registered 4:1 select cell s2. Drives its D0..D3 data lanes, its A1/B1/A0/B0 select pins and its clr pin.
- Accepts four independent valid/ready input lanes, buffers one word per lane, and picks one lane per cycle round-robin.
- Produces out_valid/out_lane tags aligned with the s2 registered output, so downstream logic knows which lane s2.out carries.

Parameters:
N, 1, data width per lane; must match the N of the s2 instance being fed.

Ports:
clk  input  1  rising-edge clock, shared with s2
clr_n  input  1  asynchronous active-low reset
in_data0..in_data3  input  N each  lane k write data
in_valid  input  4  bit k = lane k offers in_data k
in_ready  output  4  bit k = lane k accepts this cycle
D0, D1, D2, D3  output  N each  lane buffer contents, to s2 D0..D3
A1, B1, A0, B0  output  1 each  s2 select pins
s2_clr  output  1  to s2 clr; high when no lane is granted
out_valid  output  1  s2.out holds a granted word this cycle
out_lane  output  2  lane index of the word in s2.out

Behaviour:
- State per lane k:
  - buf_q[k] (N bits), full[k] (1 bit).
  - Shared rr pointer ptr (2 bits).
  - Output tags out_valid_q and out_lane_q.
- Reset (clr_n low, asynchronous, any cycle, including mid-transfer):
  - full=0000, buf_q=0, ptr=0, out_valid=0, out_lane=0.
  - in_ready forced 0000 while clr_n is low.
  - Consequently s2_clr=1 and A1=B1=A0=B0=0.
  - Release is synchronous to the next rising edge with clr_n high.
- Lane data outputs: Dk = buf_q[k], registered, no combinational path from in_data.
- Arbitration (combinational from registered state):
  - Scan full[] starting at index ptr, wrapping 3->0. The first full lane is grant g, and gv=1.
  - If no lane is full: gv=0.
- Select encoding. s2 decodes S1=A1|B1 and S0=A0&B0.
  - When gv=1: A1=g[1], B1=0, A0=g[0], B0=g[0].
  - When gv=0: all select pins 0.
  - s2_clr = ~gv.
- Handshake:
  - in_ready[k] = clr_n & (~full[k] | (gv & g==k)).
  - Lane k transfers on an edge where in_valid[k] & in_ready[k]: buf_q[k]<=in_data k, full[k]<=1.
- Consume: on every edge with gv=1, full[g]<=0 unless lane g transfers on the same edge. Simultaneous consume and refill keeps full[g]=1 and loads the new word.
- Pointer: on an edge with gv=1, ptr<=g+1 mod 4 (3 wraps to 0). Unchanged when gv=0.
- Tags:
  - On every edge, out_valid<=gv and out_lane<=(gv ? g : 0).
  - s2 captures D[g] on the same edge, so out_valid/out_lane align cycle-for-cycle with s2.out.
  - When out_valid=0, s2.out is 0 because s2_clr was high.
- Latency: a word accepted at edge t can be granted in cycle t+1 and appears on s2.out with out_valid=1 after edge t+1. Minimum 2 edges from input handshake to s2.out.
- Throughput: one word per cycle aggregate. A single continuously valid lane sustains one word per cycle with no bubbles.
- Fairness: a full lane waits at most 3 grants before service.
- Ordering: words within one lane are delivered in acceptance order. There is no cross-lane ordering guarantee.
- in_data/in_valid are ignored while clr_n is low. No word is lost or duplicated across any sequence.

Test Plan:
- Reset: drive N=4 traffic, pull clr_n low mid-cycle -> immediately full=0000, in_ready=0000, s2_clr=1, out_valid=0, ptr=0. After release, the first grant goes to lane 0 when lanes 0..3 are all full.
- Single word: lane 2 pushes 4'hA at edge 0 -> cycle 1: A1=1, B1=0, A0=0, B0=0, s2_clr=0. After edge 1: out_valid=1, out_lane=2, s2.out=4'hA. Cycle 2: s2_clr=1.
- All lanes loaded on one edge with 4'h1, 4'h2, 4'h3, 4'h4, ptr=0 -> out_lane 0,1,2,3 on four consecutive cycles, s2.out 1,2,3,4. Then out_valid=0 and s2.out=0.
- Fairness/wrap: lanes 0 and 3 held valid continuously -> grants alternate 0,3,0,3. ptr goes 1, 0 (wrap from 3), 1, 0. No lane is starved.
- Streaming: lane 1 valid every cycle with data 1,2,3,... -> in_ready[1] stays 1 after the first accept. s2.out shows 1,2,3,... one per cycle with out_lane=1 and no gaps.
- Idle: in_valid=0000 for 10 cycles -> s2_clr=1, select pins 0, out_valid=0, s2.out=0 every cycle.
